// File: rtl/fsmc_pkg.sv
// fsmc_pkg: FSMC master/slave shared state encoding and timing-parameter limits.
package fsmc_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, AHOLD, DATA, TURN} fsmc_mst_state_e;
  localparam int MIN_ADDSET  = 1;
  localparam int MIN_ADDHLD  = 1;
  localparam int MIN_DATASET = 3;
  localparam int MIN_BUSTURN = 2;
  function automatic int fsmc_max4(int a, int b, int c, int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/fsmc_phase_counter.sv
// fsmc_phase_counter: loadable down-counter; done while the count sits at zero.
module fsmc_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/fsmc_master.sv
// fsmc_master: FSMC initiator generating multiplexed NE/NADV/NWE/NOE bus cycles.
// FSMC_MASTER_RD_INREG_EN: read data passes through an input flop, rvalid one cycle later.
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int ADDSET     = 2,
  parameter int ADDHLD     = 1,
  parameter int DATASET    = 4,
  parameter int BUSTURN    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  output logic                  ready,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  inout  wire  [ADDR_WIDTH-1:0] AD,
  output logic                  NE,
  output logic                  NADV,
  output logic                  NWE,
  output logic                  NOE
);
  localparam int CW = $clog2(fsmc_max4(ADDSET, ADDHLD, DATASET, BUSTURN)) + 1;
  if (ADDSET < MIN_ADDSET) begin : g_err_addset
    $error("ADDSET below minimum");
  end
  if (ADDHLD < MIN_ADDHLD) begin : g_err_addhld
    $error("ADDHLD below minimum");
  end
  if (DATASET < MIN_DATASET) begin : g_err_dataset
    $error("DATASET below minimum");
  end
  if (BUSTURN < MIN_BUSTURN) begin : g_err_busturn
    $error("BUSTURN below minimum");
  end
  fsmc_mst_state_e       state;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] ad_out;
  logic                  oe_hi, oe_lo;
  logic                  load, done, accept;
  logic [CW-1:0]         value;
  assign AD[ADDR_WIDTH-1:DATA_WIDTH] = oe_hi ? ad_out[ADDR_WIDTH-1:DATA_WIDTH] : 'z;
  assign AD[DATA_WIDTH-1:0]          = oe_lo ? ad_out[DATA_WIDTH-1:0] : 'z;
  assign accept = state == IDLE && req && ready;
  always_comb begin
    load  = accept || (state != IDLE && state != TURN && done);
    value = state == IDLE  ? CW'(ADDSET - 1) :
            state == ADDR  ? CW'(ADDHLD - 1) :
            state == AHOLD ? CW'(DATASET - 1) : CW'(BUSTURN - 1);
  end
  fsmc_phase_counter #(.W(CW)) u_cnt (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .done(done)
  );
`ifdef FSMC_MASTER_RD_INREG_EN
  logic [DATA_WIDTH-1:0] ad_in_q;
  logic                  rd_pend;
  always_ff @(posedge clk)
    if (!reset_n) ad_in_q <= '0;
    else ad_in_q <= AD[DATA_WIDTH-1:0];
`endif
  always_ff @(posedge clk) begin
    rvalid <= 1'b0;
    if (!reset_n) begin
      state   <= IDLE;
      ready   <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ad_out  <= '0;
      oe_hi   <= 1'b0;
      oe_lo   <= 1'b0;
      NE      <= 1'b1;
      NADV    <= 1'b1;
      NWE     <= 1'b1;
      NOE     <= 1'b1;
`ifdef FSMC_MASTER_RD_INREG_EN
      rd_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            state   <= ADDR;
            ready   <= 1'b0;
            busy    <= 1'b1;
            wr_q    <= wr;
            wdata_q <= wdata;
            ad_out  <= addr;
            oe_hi   <= 1'b1;
            oe_lo   <= 1'b1;
            NE      <= 1'b0;
            NADV    <= 1'b0;
          end
        end
        ADDR: if (done) begin
          state <= AHOLD;
          NADV  <= 1'b1;
        end
        AHOLD: if (done) begin
          state                    <= DATA;
          NWE                      <= !wr_q;
          NOE                      <= wr_q;
          oe_lo                    <= wr_q;
          ad_out[DATA_WIDTH-1:0]   <= wdata_q;
        end
        DATA: if (done) begin
          state <= TURN;
          NE    <= 1'b1;
          NWE   <= 1'b1;
          NOE   <= 1'b1;
          oe_hi <= 1'b0;
          oe_lo <= 1'b0;
`ifdef FSMC_MASTER_RD_INREG_EN
          rd_pend <= !wr_q;
`else
          if (!wr_q) begin
            rdata  <= AD[DATA_WIDTH-1:0];
            rvalid <= 1'b1;
          end
`endif
        end
        TURN: begin
`ifdef FSMC_MASTER_RD_INREG_EN
          if (rd_pend) begin
            rdata   <= ad_in_q;
            rvalid  <= 1'b1;
            rd_pend <= 1'b0;
          end
`endif
          if (done) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fsmc_master.md
# fsmc_master

FPGA-side FSMC initiator that generates multiplexed address/data bus cycles (NADV/NWE/NOE/NE) on the same `AD` bus layout our FSMC slave decodes: upper `AD` bits select a module, lower `DATA_WIDTH` bits carry offset then data. It sits between a simple request/response user port and the physical pins. It serves as the MCU-emulating end for board-to-board links and for closed-loop regression of the slave side.

## Interface
- `ADDR_WIDTH`, 18, total `AD` width (module-select bits + data bits)
- `DATA_WIDTH`, 16, multiplexed address/data width
- `ADDSET`, 2, cycles NADV low with address driven (≥1)
- `ADDHLD`, 1, cycles NADV high, address still driven, before the data phase (≥1)
- `DATASET`, 4, cycles NWE/NOE low (≥3, so the slave's 2-flop sync sees the strobe)
- `BUSTURN`, 4, idle cycles after the data phase (≥ slave data-hold cycles + 2)
- `clk` in 1 system clock
- `reset_n` in 1 reset; **one clock; reset is synchronous and active-low**
- `req` in 1 transaction request
- `ready` out 1 master can accept; high only in IDLE
- `wr` in 1 1 = write, 0 = read
- `addr` in ADDR_WIDTH full address: [ADDR_WIDTH-1:DATA_WIDTH] module select, [DATA_WIDTH-1:0] offset
- `wdata` in DATA_WIDTH write data
- `rdata` out DATA_WIDTH read data, valid with `rvalid`
- `rvalid` out 1 one-cycle pulse per completed read
- `busy` out 1 high from accept until end of TURN
- `AD` inout ADDR_WIDTH multiplexed bus
- `NE` out 1 chip enable, low active
- `NADV` out 1 address valid, low active
- `NWE` out 1 write strobe, low active
- `NOE` out 1 read strobe, low active

## Operation
- Accept on `req && ready` at a rising edge; `wr`, `addr`, `wdata` latched at that edge; `req` ignored while busy.
- FSM: IDLE → ADDR (ADDSET cycles) → AHOLD (ADDHLD) → DATA (DATASET) → TURN (BUSTURN) → IDLE.
- IDLE: NE/NADV/NWE/NOE = 1; `AD` fully Z.
- ADDR: NE=0, NADV=0, `AD` = latched addr.
- AHOLD: NADV=1, `AD` = addr (slave latches on NADV rising).
- DATA write: NWE=0; `AD[DATA_WIDTH-1:0]` = wdata; upper bits keep module select.
- DATA read: NOE=0; `AD[DATA_WIDTH-1:0]` = Z; upper bits keep module select; rdata captured from `AD[DATA_WIDTH-1:0]` in the last DATA cycle.
- TURN: all strobes 1; NE=1; `AD` fully Z. No master drive while the slave may still hold data.
- Phase counter: down-counter loaded with phase length − 1 on each entry; exits at 0; width `$clog2` of the maximum parameter plus 1.
- Parameters below their minimums cause an elaboration `$error`.
- Reset mid-transaction: at the next edge with reset_n=0 → IDLE, strobes 1, `AD` Z, rvalid=0, transaction dropped.

## Timing
- Reset values: ready=0 during reset, 1 on the first cycle after release; busy=0; rvalid=0; rdata=0; NE=NADV=NWE=NOE=1; `AD` Z.
- All outputs are registered. ADDR starts on the cycle after the accept edge.
- Transaction length = ADDSET+ADDHLD+DATASET+BUSTURN cycles. Defaults: 11 cycles, then ready=1.
- Read: rvalid asserts on the first TURN cycle (cycle ADDSET+ADDHLD+DATASET+1 after accept).
- Back-to-back: `req` held high → next accept on the first IDLE cycle, i.e. 1 IDLE cycle between transactions.

## Configuration
- `FSMC_MASTER_RD_INREG_EN` defined: `AD` lower bits pass through an input flop every cycle. rdata is taken from that flop one cycle after the last DATA cycle. rvalid moves to TURN cycle 2. Requires BUSTURN ≥2.
- Undefined: direct capture as in Operation; rvalid on TURN cycle 1.

## Structure
- Shared package `fsmc_pkg`: state enum `fsmc_mst_state_e` (IDLE, ADDR, AHOLD, DATA, TURN) and parameter-limit constants (min DATASET=3). The slave side references the same package.
- One sub-module: `fsmc_phase_counter`, a loadable down-counter with a `done` flag.

## Test plan
- Write, defaults, addr=0x1_0042, wdata=0xBEEF → NADV low 2 cycles with AD=0x10042; NWE low 4 cycles with AD=0x1BEEF; ready returns after 11 cycles.
- Read, addr=0x0_0010, bench drives AD[15:0]=0x5A5A while NOE=0 → rvalid pulses once with rdata=0x5A5A; AD[15:0] never driven by the master in DATA/TURN.
- Closed loop with the FSMC slave: 1000 random writes then reads-back to module 0/1 → 0 mismatches.
- Back-to-back `req` held: write then read → exactly 1 IDLE cycle between; no AD contention (no X on AD).
- reset_n=0 in the 2nd DATA cycle of a write → next edge: NWE=1, AD Z, ready=0; after release ready=1, no rvalid.
- `FSMC_MASTER_RD_INREG_EN` defined, read → rvalid one cycle later than undefined build; same rdata.
